// File: rtl/fixed_stream_pkg.sv
// Shared types and width helpers for the fixed-point vector streamer.
package fixed_stream_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_e;

  function automatic int addr_width(input int depth);
    if (depth > 1) begin
      return $clog2(depth);
    end else begin
      return 1;
    end
  endfunction

  function automatic int len_width(input int depth);
    return addr_width(depth) + 1;
  endfunction

  function automatic int max_width(input int a, input int b);
    if (a > b) begin
      return a;
    end else begin
      return b;
    end
  endfunction

endpackage

// File: rtl/fixed_vec_chan.sv
// One transmit channel: element buffer, read pointer and valid/last/data sequencing.
module fixed_vec_chan
  import fixed_stream_pkg::*;
#(
  parameter int DW    = 16,
  parameter int DEPTH = 16,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          start_i,
  input  logic [AW:0]   len_i,
  input  logic          ready_i,
  output logic [DW-1:0] data_o,
  output logic          valid_o,
  output logic          last_o,
  output logic          finished_o
);

  localparam logic [AW-1:0] ADDR_ZERO = '0;
  localparam logic [AW-1:0] ADDR_ONE  = AW'(1);
  localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] ptr_q, ptr_d, ptr_inc_s;
  logic [DW-1:0] data_q, data_d, first_s;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          fin_q, fin_d;
  logic [AW:0]   len_m1_s;

  // Element storage; contents deliberately survive reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // Beat sequencing; a write racing the start is forwarded so element 0 is current.
  always_comb begin
    ptr_d     = ptr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    fin_d     = fin_q;
    ptr_inc_s = ptr_q + ADDR_ONE;
    len_m1_s  = len_i - LEN_ONE;
    if (wr_en_i && (wr_addr_i == ADDR_ZERO)) begin
      first_s = wr_data_i;
    end else begin
      first_s = mem_q[ADDR_ZERO];
    end
    if (start_i) begin
      ptr_d   = ADDR_ZERO;
      data_d  = first_s;
      valid_d = 1'b1;
      last_d  = (len_i == LEN_ONE);
      fin_d   = 1'b0;
    end else if (valid_q && ready_i) begin
      if (last_q) begin
        data_d  = '0;
        valid_d = 1'b0;
        last_d  = 1'b0;
        fin_d   = 1'b1;
      end else begin
        ptr_d  = ptr_inc_s;
        data_d = mem_q[ptr_inc_s];
        last_d = ({1'b0, ptr_inc_s} == len_m1_s);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      fin_q   <= fin_d;
    end
  end

  assign data_o     = data_q;
  assign valid_o    = valid_q;
  assign last_o     = last_q;
  assign finished_o = fin_q;

endmodule

// File: rtl/fixed_vec_streamer.sv
// Transmit end of the A/B operand streams: command FSM, length latch and write steering.
module fixed_vec_streamer
  import fixed_stream_pkg::*;
#(
  parameter int WI1   = 6,
  parameter int WF1   = 10,
  parameter int WI2   = 4,
  parameter int WF2   = 8,
  parameter int DEPTH = 16,
  parameter int AW    = addr_width(DEPTH)
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          wr_en,
  input  logic                                          wr_sel,
  input  logic [AW-1:0]                                 wr_addr,
  input  logic [max_width(WI1+WF1, WI2+WF2)-1:0]        wr_data,
  input  logic                                          cmd_valid,
  output logic                                          cmd_ready,
  input  logic [AW:0]                                   cmd_len,
  output logic signed [WI1+WF1-1:0]                     A_data,
  output logic                                          A_valid,
  input  logic                                          A_ready,
  output logic                                          A_last,
  output logic signed [WI2+WF2-1:0]                     B_data,
  output logic                                          B_valid,
  input  logic                                          B_ready,
  output logic                                          B_last,
  output logic                                          busy,
  output logic                                          done
);

  localparam int            DWA       = WI1 + WF1;
  localparam int            DWB       = WI2 + WF2;
  localparam int            LW        = AW + 1;
  localparam logic [AW:0]   DEPTH_LEN = LW'(DEPTH);
  localparam logic [AW:0]   LEN_ZERO  = '0;

  state_e       state_q, state_d;
  logic [AW:0]  len_q, len_d, len_sat_s;
  logic         cmd_ready_q, busy_q, done_q;
  logic         accept_s, start_s, wr_ok_s;
  logic         a_fin_s, b_fin_s, a_end_s, b_end_s;

  // Command accept, length saturation and end-of-channel detection.
  always_comb begin
    accept_s = cmd_valid && cmd_ready_q;
    if (cmd_len > DEPTH_LEN) begin
      len_sat_s = DEPTH_LEN;
    end else begin
      len_sat_s = cmd_len;
    end
    if (accept_s) begin
      len_d = len_sat_s;
    end else begin
      len_d = len_q;
    end
    start_s = accept_s && (len_sat_s != LEN_ZERO);
    wr_ok_s = wr_en && (state_q == IDLE);
    a_end_s = a_fin_s || (A_valid && A_ready && A_last);
    b_end_s = b_fin_s || (B_valid && B_ready && B_last);
  end

  // Next-state logic; DONE is reached on the edge of the later final beat.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          if (len_sat_s == LEN_ZERO) begin
            state_d = DONE;
          end else begin
            state_d = STREAM;
          end
        end else begin
          state_d = IDLE;
        end
      end
      STREAM: begin
        if (a_end_s && b_end_s) begin
          state_d = DONE;
        end else begin
          state_d = STREAM;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, length latch and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      len_q       <= '0;
      cmd_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      cmd_ready_q <= (state_d == IDLE);
      busy_q      <= (state_d != IDLE);
      done_q      <= (state_d == DONE);
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

  fixed_vec_chan #(.DW(DWA), .DEPTH(DEPTH), .AW(AW)) u_chan_a (
    .clk_i      (clk),
    .reset_i    (reset),
    .wr_en_i    (wr_ok_s && !wr_sel),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data[DWA-1:0]),
    .start_i    (start_s),
    .len_i      (len_d),
    .ready_i    (A_ready),
    .data_o     (A_data),
    .valid_o    (A_valid),
    .last_o     (A_last),
    .finished_o (a_fin_s)
  );

  fixed_vec_chan #(.DW(DWB), .DEPTH(DEPTH), .AW(AW)) u_chan_b (
    .clk_i      (clk),
    .reset_i    (reset),
    .wr_en_i    (wr_ok_s && wr_sel),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data[DWB-1:0]),
    .start_i    (start_s),
    .len_i      (len_d),
    .ready_i    (B_ready),
    .data_o     (B_data),
    .valid_o    (B_valid),
    .last_o     (B_last),
    .finished_o (b_fin_s)
  );

endmodule

// File: tb/tb_fixed_vec_streamer.sv
// Directed bench for fixed_vec_streamer with hand-derived beat timing.
module tb_fixed_vec_streamer;

  logic        clk = 1'b0;
  logic        reset, wr_en, wr_sel, cmd_valid, cmd_ready;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [4:0]  cmd_len;
  logic [15:0] A_data;
  logic [11:0] B_data;
  logic        A_valid, A_ready, A_last, B_valid, B_ready, B_last, busy, done;

  always #5 clk = ~clk;

  fixed_vec_streamer dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
    .wr_data(wr_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .A_data(A_data), .A_valid(A_valid), .A_ready(A_ready), .A_last(A_last),
    .B_data(B_data), .B_valid(B_valid), .B_ready(B_ready), .B_last(B_last),
    .busy(busy), .done(done)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc, a_last_cyc, b_last_cyc, done_cyc, done_cnt;
  logic [15:0] ma [16];
  logic [11:0] mb [16];
  logic [15:0] a_q [$];
  logic        a_lq [$];
  logic [11:0] b_q [$];
  logic        b_lq [$];
  logic        a_stall, b_stall;
  logic [16:0] a_hold;
  logic [12:0] b_hold;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy_a(input int mode, input int c);
    if (mode == 1) return (c % 4 == 0) || (c % 4 == 3);
    return 1'b1;
  endfunction

  function automatic logic rdy_b(input int mode, input int c);
    if (mode == 1) return (c > 5);
    return 1'b1;
  endfunction

  task automatic wr(input logic sel, input logic [3:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  // One cycle: apply readys, sample outputs at the falling edge, log beats, advance.
  task automatic cycle(input logic ar, input logic br);
    A_ready = ar;
    B_ready = br;
    if (a_stall) chk("a_hold", {A_valid, A_last, A_data}, {1'b1, a_hold});
    if (b_stall) chk("b_hold", {B_valid, B_last, B_data}, {1'b1, b_hold});
    if (A_valid && ar) begin
      a_q.push_back(A_data); a_lq.push_back(A_last);
      if (A_last) a_last_cyc = cyc;
    end
    if (B_valid && br) begin
      b_q.push_back(B_data); b_lq.push_back(B_last);
      if (B_last) b_last_cyc = cyc;
    end
    a_stall = A_valid && !ar; a_hold = {A_last, A_data};
    b_stall = B_valid && !br; b_hold = {B_last, B_data};
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    cyc++;
    @(negedge clk);
  endtask

  // mode 0: readys high, 1: backpressure, 2: cmd_valid held, 3: write attempt mid-stream
  task automatic run_stream(input int len, input int mode);
    a_q.delete(); a_lq.delete(); b_q.delete(); b_lq.delete();
    cyc = 0; a_last_cyc = -1; b_last_cyc = -1; done_cyc = -1; done_cnt = 0;
    a_stall = 1'b0; b_stall = 1'b0;
    cmd_valid = 1'b1;
    cmd_len   = 5'(len);
    cycle(1'b1, 1'b1);
    wr_en     = 1'b0;
    cmd_valid = (mode == 2);
    while (done_cnt == 0 && cyc < 60) begin
      if (mode == 3) begin
        wr_en = (cyc == 2); wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'hAAAA;
      end
      chk("busy_during", {31'd0, busy}, 32'd1);
      chk("cmd_ready_during", {31'd0, cmd_ready}, 32'd0);
      cycle(rdy_a(mode, cyc), rdy_b(mode, cyc));
    end
    wr_en = 1'b0;
    chk("done_count", done_cnt, 1);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);
  endtask

  task automatic check_stream(input int len, input int exp_done, input int exp_al, input int exp_bl);
    chk("a_beats", a_q.size(), len);
    chk("b_beats", b_q.size(), len);
    for (int i = 0; i < len && i < a_q.size(); i++) begin
      chk("a_data", {16'd0, a_q[i]}, {16'd0, ma[i]});
      chk("a_last", {31'd0, a_lq[i]}, {31'd0, (i == len - 1)});
    end
    for (int i = 0; i < len && i < b_q.size(); i++) begin
      chk("b_data", {20'd0, b_q[i]}, {20'd0, mb[i]});
      chk("b_last", {31'd0, b_lq[i]}, {31'd0, (i == len - 1)});
    end
    chk("done_cycle", done_cyc, exp_done);
    chk("a_final_cycle", a_last_cyc, exp_al);
    chk("b_final_cycle", b_last_cyc, exp_bl);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'd0;
    cmd_valid = 1'b0; cmd_len = 5'd0; A_ready = 1'b0; B_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_valids", {30'd0, A_valid, B_valid}, 32'd0);
    chk("rst_lasts", {30'd0, A_last, B_last}, 32'd0);
    chk("rst_busy_done", {30'd0, busy, done}, 32'd0);
    chk("rst_a_data", {16'd0, A_data}, 32'd0);
    chk("rst_b_data", {20'd0, B_data}, 32'd0);
    reset = 1'b0;

    ma[0] = 16'h1234; ma[1] = 16'h0400; ma[2] = 16'hFC00; ma[3] = 16'h7FFF;
    mb[0] = 12'h467;  mb[1] = 12'h100;  mb[2] = 12'hF00;  mb[3] = 12'h7FF;
    for (int i = 4; i < 16; i++) begin
      ma[i] = 16'h8100 + 16'(i);
      mb[i] = 12'h8C0 + 12'(i);
    end
    for (int i = 0; i < 16; i++) begin
      wr(1'b0, 4'(i), ma[i]);
      wr(1'b1, 4'(i), {4'd0, mb[i]});
    end

    run_stream(4, 0);  check_stream(4, 5, 4, 4);
    run_stream(4, 1);  check_stream(4, 10, 8, 9);
    run_stream(0, 0);  check_stream(0, 1, -1, -1);
    run_stream(20, 0); check_stream(16, 17, 16, 16);
    run_stream(4, 3);  check_stream(4, 5, 4, 4);
    run_stream(1, 0);  check_stream(1, 2, 1, 1);

    // Command held high: second stream starts right after returning to IDLE.
    run_stream(4, 2);  check_stream(4, 5, 4, 4);
    cycle(1'b1, 1'b1);
    cmd_valid = 1'b0;
    chk("restart_valid", {31'd0, A_valid}, 32'd1);
    chk("restart_data", {16'd0, A_data}, {16'd0, ma[0]});
    repeat (4) cycle(1'b1, 1'b1);
    chk("restart_done", {31'd0, done}, 32'd1);
    cycle(1'b1, 1'b1);

    // Reset after two beats of a four-beat stream.
    cmd_valid = 1'b1; cmd_len = 5'd4;
    cycle(1'b1, 1'b1);
    cmd_valid = 1'b0;
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    chk("mid_a_data", {16'd0, A_data}, {16'd0, ma[2]});
    reset = 1'b1;
    cycle(1'b1, 1'b1);
    reset = 1'b0;
    chk("abort_valids", {30'd0, A_valid, B_valid}, 32'd0);
    chk("abort_lasts", {30'd0, A_last, B_last}, 32'd0);
    chk("abort_done_busy", {30'd0, done, busy}, 32'd0);
    chk("abort_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cycle(1'b1, 1'b1);
    chk("abort_no_done", {31'd0, done}, 32'd0);
    run_stream(2, 0);  check_stream(2, 3, 2, 2);

    // Write to A[0] in the same cycle as the command is accepted.
    wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 16'h5A5A;
    ma[0] = 16'h5A5A;
    run_stream(1, 0);  check_stream(1, 2, 1, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fixed_vec_streamer.md
Name: fixed_vec_streamer

Overview:
- Upstream source for the fixed-point multiply-accumulate block.
- Holds two locally loaded operand vectors: A in Q(WI1.WF1) and B in Q(WI2.WF2).
- On a command, transmits both vectors on independent valid/ready/last channels. These are exactly the A and B channels the accumulator receives.
- Replaces bench-driven stimulus in the integrated datapath; it is the transmit end of the A/B stream interface.

Parameters:
- WI1, 6, integer bits of A elements
- WF1, 10, fractional bits of A elements
- WI2, 4, integer bits of B elements
- WF2, 8, fractional bits of B elements
- DEPTH, 16, maximum vector length (elements per buffer)
- AW, $clog2(DEPTH), buffer address width (derived, not overridden)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  buffer write strobe
- wr_sel  in  1  0 = write A buffer, 1 = write B buffer
- wr_addr  in  AW  element index
- wr_data  in  max(WI1+WF1,WI2+WF2)  element value; LSBs used for the narrower buffer
- cmd_valid  in  1  start request
- cmd_ready  out  1  high in IDLE only
- cmd_len  in  AW+1  elements to send on each channel
- A_data  out  WI1+WF1  signed A element
- A_valid  out  1
- A_ready  in  1
- A_last  out  1  final A element
- B_data  out  WI2+WF2  signed B element
- B_valid  out  1
- B_ready  in  1
- B_last  out  1  final B element
- busy  out  1  streaming in progress
- done  out  1  one-cycle pulse when both channels have finished

Behaviour:
- Reset:
  - All valid/last/busy/done = 0, cmd_ready = 1, A_data = B_data = 0, state = IDLE, pointers = 0.
  - Buffer contents are not cleared.
- Reset mid-stream: aborts immediately, with no done pulse; the next cycle matches post-reset.
- Buffer writes:
  - Accepted only in IDLE; wr_en while busy is ignored.
  - A write takes effect at the clock edge.
  - A write and a command accept in the same cycle: the write lands first, so the stream sees the new value.
- Command accept: cmd_valid && cmd_ready at edge T.
  - Latch len = min(cmd_len, DEPTH); cmd_len > DEPTH saturates to DEPTH.
- cmd_len == 0:
  - Go to DONE; done = 1 for cycle T+1, no beats on either channel, back to IDLE at T+2.
- States:
  - IDLE -> STREAM on accept with len > 0.
  - STREAM -> DONE when both channels have completed their final beat.
  - DONE -> IDLE unconditionally after one cycle.
- STREAM, per channel (independent sequencers):
  - valid rises at T+1 (registered); the first element is buf[0].
  - A beat completes when valid && ready at an edge; the pointer then increments.
  - Data changes only after a completed beat; data and last are held stable while valid && !ready.
  - last = 1 exactly while ptr == len-1 and valid = 1.
  - After the final beat, valid and last drop next cycle and data returns to 0; the channel idles until the other channel finishes.
  - With ready held high, one beat per cycle, and the final beat is at T+len.
- Channels complete independently; skewed ready patterns are legal.
- done asserts the cycle after the later of the two final beats.
- busy = 1 in STREAM and DONE.
- cmd_ready = 0 outside IDLE; cmd_valid is ignored there.
- No arithmetic on the data; elements are passed bit-exact, sign preserved.

Decomposition:
- Package fixed_stream_pkg holds:
  - state enum {IDLE, STREAM, DONE}
  - the AW/length width helper
  - the max-width function used for wr_data
- One sub-module, fixed_vec_chan, parameterised by data width and DEPTH:
  - contains the buffer, pointer, valid/last generation and a "finished" flag
  - instantiated twice, for A and B
- The top level holds the FSM, command latch and write steering.

Test Plan:
- Basic stream:
  - Stimulus: load A[0..3] = 16'h1234, 16'h0400, 16'hFC00, 16'h7FFF and B[0..3] = 12'h467, 12'h100, 12'hF00, 12'h7FF; cmd_len = 4; readys high.
  - Response: 4 beats per channel on consecutive cycles in that order; A_last and B_last on beat 4; done 1 cycle after the last beat.
- Backpressure:
  - Stimulus: same vectors; A_ready toggles 1,0,0,1…; B_ready low for 5 cycles.
  - Response: data/last stable while stalled; no beat lost or duplicated; done only after the later channel's last beat.
- Zero and oversize length:
  - Stimulus: cmd_len = 0, then cmd_len = 20 with DEPTH = 16.
  - Response: for cmd_len = 0, no valid and done at T+1; for cmd_len = 20, exactly 16 beats per channel with last on index 15.
- Writes while busy:
  - Stimulus: wr_en to A[0] = 16'hAAAA during STREAM, then a new cmd_len = 1.
  - Response: the second stream still sends the original A[0].
- Command while busy:
  - Stimulus: cmd_valid held high throughout a stream.
  - Response: cmd_ready = 0 until IDLE; a second stream starts the cycle after done falls.
- Reset mid-stream:
  - Stimulus: reset asserted after 2 of 4 beats.
  - Response: all valid/last = 0 next cycle; no done; cmd_ready = 1; a subsequent cmd_len = 2 sends buf[0], buf[1].
